// File: rtl/mult_share_pkg.sv
// mult_share_pkg
// Shared types and constants for the multiplier-sharing arbiter and its
// round-robin picker.
//   state_t      : arbiter sequencer states
//   grant_idx_t  : requester index, wide enough for the largest supported
//                  requester count
//   DEFAULT_TIMEOUT : default completion watchdog, in cycles
package mult_share_pkg;

  localparam int MAX_NUM_REQ     = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [$clog2(MAX_NUM_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority picker. Scans the request vector starting
// one position above last_grant and wrapping, and returns the first set bit.
//   req        in  NUM_REQ  request vector
//   last_grant in  idx      most recently served requester
//   grant_oh   out NUM_REQ  one-hot winner (zero when nothing requested)
//   grant_idx  out idx      winner index (zero when nothing requested)
//   any        out 1        at least one request present
module rr_pick
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  grant_idx_t         last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output grant_idx_t         grant_idx,
  output logic               any
);

  // Outer loop walks priority order (k=1 is highest), inner loop keeps every
  // vector index constant so no variable bit-select is needed.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (i == ((int'(last_grant) + k) % NUM_REQ))) begin
          any         = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = grant_idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one fixed-point multiplier among NUM_REQ requesters. A round-robin
// winner is accepted in IDLE, its operands are latched and issued to the
// multiplier for one cycle, the product (or a watchdog abort) is captured and
// held on the shared response bus until the granted requester takes it.
//
//   state | meaning
//   IDLE  | no transaction; accept round-robin winner, latch its operands
//   ISSUE | mul_valid pulse, wait counter cleared
//   WAIT  | waiting for mul_complete or watchdog expiry
//   RESP  | rsp_valid to granted requester until its rsp_ready
//
// Ports:
//   clock, reset            clock and async active-high reset
//   req_valid/req_a/req_b   requester operands, requester i at slice i
//   req_ready               one-hot accept pulse (combinational, IDLE only)
//   rsp_valid/rsp_data/rsp_err/rsp_ready  result return path
//   mul_valid/mul_a/mul_b   operands to multiplier
//   mul_complete/mul_product/mul_ack      multiplier result handshake
//   busy                    transaction in progress
//   timeout_sticky          any watchdog abort since reset
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          mul_valid,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic                          mul_complete,
  input  logic [DATA_WIDTH-1:0]         mul_product,
  output logic                          mul_ack,
  output logic                          busy,
  output logic                          timeout_sticky
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  grant_idx_t            last_grant;
  grant_idx_t            grant_idx_q;
  logic [NUM_REQ-1:0]    grant_oh_q;

  logic [NUM_REQ-1:0]    pick_oh;
  grant_idx_t            pick_idx;
  logic                  pick_any;

  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic                  err_q, sticky_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  timeout_hit;
  logic                  rsp_accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  // Only the granted requester's rsp_ready counts.
  assign rsp_accept  = |(rsp_ready & grant_oh_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_complete || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_valid = 1'b0;
    mul_ack   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    req_ready = pick_oh;
      ISSUE:   mul_valid = 1'b1;
      WAIT:    mul_ack   = mul_complete;
      RESP:    rsp_valid = grant_oh_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant  <= grant_idx_t'(NUM_REQ - 1);
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a_q      <= sel_a;
            op_b_q      <= sel_b;
            grant_oh_q  <= pick_oh;
            grant_idx_q <= pick_idx;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // A completion in the expiry cycle wins over the abort.
          if (mul_complete) begin
            result_q <= mul_product;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_accept) last_grant <= grant_idx_q;
        end
        default: ;
      endcase
    end
  end

  assign mul_a          = op_a_q;
  assign mul_b          = op_b_q;
  assign rsp_data       = result_q;
  assign rsp_err        = err_q;
  assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [DW-1:0]    rsp_data, mul_a, mul_b, mul_product;
  logic             rsp_err, mul_valid, mul_complete, mul_ack, busy, timeout_sticky;

  int               checks = 0;
  int               failures = 0;
  int               ack_total = 0;
  int               stub_delay = 0;
  logic [DW-1:0]    stub_product = '0;

  mult_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .rsp_ready      (rsp_ready),
    .mul_valid      (mul_valid),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_complete   (mul_complete),
    .mul_product    (mul_product),
    .mul_ack        (mul_ack),
    .busy           (busy),
    .timeout_sticky (timeout_sticky)
  );

  always #5 clock = ~clock;

  // Multiplier stub: complete pulses stub_delay WAIT cycles after mul_valid
  // (0 = first WAIT cycle); a negative delay never completes.
  initial begin : stub
    int cnt;
    bit pend;
    cnt = 0;
    pend = 1'b0;
    mul_complete = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clock); #1;
      mul_complete = 1'b0;
      mul_product = '0;
      if (reset) pend = 1'b0;
      else if (mul_valid) begin
        pend = (stub_delay >= 0);
        cnt = stub_delay;
      end else if (pend) begin
        if (cnt == 0) begin
          mul_complete = 1'b1;
          mul_product = stub_product;
          pend = 1'b0;
        end else cnt--;
      end
    end
  end

  always @(negedge clock) if (mul_ack) ack_total++;

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] prod;
    int            delay;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    logic          exp_sticky;
  } vec_t;

  vec_t vecs[5];

  task automatic run_txn(input vec_t v);
    int base;
    int lat;
    int extra_valid;
    logic [NR-1:0] oh;
    oh = NR'(1) << v.idx;
    wait_idle();
    @(posedge clock); #1;
    base = ack_total;
    stub_delay = v.delay;
    stub_product = v.prod;
    req_a = '0;
    req_b = '0;
    req_a[v.idx*DW +: DW] = v.a;
    req_b[v.idx*DW +: DW] = v.b;
    req_valid = oh;
    @(negedge clock);
    check("req_ready", 32'(req_ready), 32'(oh));
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    check("mul_valid_issue", 32'(mul_valid), 32'd1);
    check("mul_a", mul_a, v.a);
    check("mul_b", mul_b, v.b);
    lat = 0;
    extra_valid = 0;
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clock);
      if (mul_valid) extra_valid++;
      if (rsp_valid != '0) begin
        lat = k;
        break;
      end
    end
    check("mul_valid_in_wait", 32'(extra_valid), 32'd0);
    check("rsp_latency", 32'(lat), v.exp_err ? 32'(TO + 1) : 32'(v.delay + 2));
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_data", rsp_data, v.exp_data);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("timeout_sticky", 32'(timeout_sticky), 32'(v.exp_sticky));
    check("mul_ack_count", 32'(ack_total - base), v.exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin : main
    int grants[$];
    int gtimes[$];
    int cyc;
    logic [NR-1:0] exp_oh;

    // idx, a, b, stub product, stub delay, err, expected data, sticky (Q.10 values)
    vecs[0] = '{2, 32'h800,  32'hC00,  32'h1800, 0,  1'b0, 32'h1800, 1'b0}; // 2.0*3.0
    vecs[1] = '{1, 32'h400,  32'h1400, 32'h1400, 3,  1'b0, 32'h1400, 1'b0}; // 1.0*5.0
    vecs[2] = '{3, 32'h200,  32'h600,  32'h300,  TO-1, 1'b0, 32'h300, 1'b0}; // complete on last cycle
    vecs[3] = '{0, 32'h1234, 32'h5678, 32'hDEAD, -1, 1'b1, 32'h0,    1'b1}; // never completes
    vecs[4] = '{2, 32'h800,  32'h800,  32'h1000, 1,  1'b0, 32'h1000, 1'b1}; // 2.0*2.0 after abort

    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mul_valid", 32'(mul_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_sticky", 32'(timeout_sticky), 32'd0);
    reset = 1'b0;

    // Round-robin with all requesters held from reset.
    @(posedge clock); #1;
    stub_delay = 0;
    stub_product = 32'h100;
    req_valid = '1;
    cyc = 0;
    for (int n = 0; n < 40 && grants.size() < 5; n++) begin
      @(negedge clock);
      if (req_ready != '0) begin
        grants.push_back(int'(req_ready));
        gtimes.push_back(cyc);
      end
      cyc++;
    end
    @(posedge clock); #1;
    req_valid = '0;
    check("rr_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < grants.size(); i++) begin
      exp_oh = NR'(1) << (i % NR);
      check("rr_grant_order", 32'(grants[i]), 32'(exp_oh));
      if (i > 0) check("rr_grant_spacing", 32'(gtimes[i] - gtimes[i-1]), 32'd4);
    end

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Backpressure on requester 1; rsp_ready on other lines must be ignored.
    wait_idle();
    @(posedge clock); #1;
    rsp_ready = 4'b1101;
    stub_delay = 0;
    stub_product = 32'h2800;   // 2.5 * 4.0
    req_a = '0;
    req_b = '0;
    req_a[1*DW +: DW] = 32'hA00;
    req_b[1*DW +: DW] = 32'h1000;
    req_valid = 4'b0010;
    @(negedge clock);
    check("bp_req_ready", 32'(req_ready), 32'b0010);
    @(posedge clock); #1;
    req_valid = 4'b0011;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clock);
      if (rsp_valid != '0) break;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("bp_rsp_data", rsp_data, 32'h2800);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("bp_hold_valid", 32'(rsp_valid), 32'b0010);
      check("bp_hold_data", rsp_data, 32'h2800);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      check("bp_no_mul_valid", 32'(mul_valid), 32'd0);
    end
    @(posedge clock); #1;
    rsp_ready = '1;
    @(negedge clock);
    check("bp_last_valid", 32'(rsp_valid), 32'b0010);
    @(negedge clock);
    check("bp_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();

    // Asynchronous reset while waiting on the multiplier.
    @(posedge clock); #1;
    stub_delay = -1;
    req_a[3*DW +: DW] = 32'h700;
    req_valid = 4'b1000;
    @(posedge clock); #1;
    req_valid = '0;
    @(posedge clock); #1;
    @(posedge clock); #3;
    check("mid_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_mul_valid", 32'(mul_valid), 32'd0);
    check("async_mul_a", mul_a, 32'd0);
    check("async_mul_b", mul_b, 32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rsp_data", rsp_data, 32'd0);
    check("async_rsp_err", 32'(rsp_err), 32'd0);
    check("async_sticky", 32'(timeout_sticky), 32'd0);
    check("async_mul_ack", 32'(mul_ack), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    stub_delay = 0;
    req_valid = '1;
    @(negedge clock);
    check("post_reset_grant", 32'(req_ready), 32'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
